ccm_out_framer: RTL



---
 rtl/ccm_pkg.sv | 17 +
 rtl/ccm_byte_fifo.sv | 47 ++++
 rtl/ccm_out_framer.sv | 114 +++++++++++
 3 files changed

// File: rtl/ccm_pkg.sv
// rtl/ccm_pkg.sv - shared CCM constants, framer state encoding and block padding helper
package ccm_pkg;

    localparam int CCM_BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } framer_state_t;

    // Round a byte count up to the next AES block boundary.
    function automatic logic [31:0] ccm_pad_len(input logic [31:0] len);
        return ((len + 32'(CCM_BLOCK_BYTES) - 32'd1) / 32'(CCM_BLOCK_BYTES)) * 32'(CCM_BLOCK_BYTES);
    endfunction

endpackage

// File: rtl/ccm_byte_fifo.sv
// rtl/ccm_byte_fifo.sv - synchronous byte FIFO with combinational head read
module ccm_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // A pop frees the slot this cycle, so a push while full still lands.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/ccm_out_framer.sv
// rtl/ccm_out_framer.sv - strips CCM block padding and frames payload onto a valid/ready stream
module ccm_out_framer
    import ccm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

    framer_state_t    state;
    framer_state_t    state_nxt;
    logic [LEN_W:0]   len_q;
    logic [LEN_W:0]   pad_len_q;
    logic [LEN_W:0]   in_cnt;
    logic [LEN_W:0]   out_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             payload;
    logic             pop;
    logic             drop;
    logic             flush_done;

    assign payload    = (state == RUN) && in_en && (in_cnt < len_q);
    assign pop        = !fifo_empty && out_ready;
    assign drop       = payload && fifo_full && !pop;
    assign flush_done = (state == FLUSH) && (state_nxt == IDLE);

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_head;
    assign out_last  = out_valid && (out_cnt + CNT_ONE == len_q);
    assign busy      = (state != IDLE);

    ccm_byte_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (payload),
        .push_data (in_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (msg_len == '0) ? FLUSH : RUN;
            end
            RUN: begin
                if (pad_len_q == '0)
                    state_nxt = FLUSH;
                else if (in_en && (in_cnt == pad_len_q - CNT_ONE))
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                // Dropped bytes mean out_cnt never reaches len; the full input count closes the message instead.
                if (fifo_empty && ((out_cnt == len_q) || (in_cnt == pad_len_q)))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            len_q     <= '0;
            pad_len_q <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= flush_done;
            if (state == IDLE && start) begin
                len_q     <= {1'b0, msg_len};
                pad_len_q <= (LEN_W+1)'(ccm_pad_len(32'(msg_len)));
                in_cnt    <= '0;
                out_cnt   <= '0;
                overflow  <= 1'b0;
            end else begin
                if (state == RUN && in_en) in_cnt  <= in_cnt + CNT_ONE;
                if (pop)                   out_cnt <= out_cnt + CNT_ONE;
                if (drop)                  overflow <= 1'b1;
            end
        end
    end

endmodule
